// File: rtl/aes_pkg.sv
// Shared AES definitions: state widths, MixColumns FSM states and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_STATE_W  = 128;
  localparam int unsigned AES_COL_W    = 32;
  localparam int unsigned AES_NUM_COLS = 4;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mixcol_state_t;

  typedef logic [AES_COL_W-1:0] aes_col_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; c is a small constant so most terms fold away.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = b;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mixcol_seq_if.sv
// Start/result handshake bundle between the round controller and mixcol_seq.
interface mixcol_seq_if;
  import aes_pkg::*;

  logic                   mixcol_enable;
  logic                   inv_mode;
  logic [AES_STATE_W-1:0] olddata;
  logic [AES_STATE_W-1:0] newdata;
  logic                   mixcol_finished;
  logic                   busy;

  modport master (
    output mixcol_enable, inv_mode, olddata,
    input  newdata, mixcol_finished, busy
  );

  modport slave (
    input  mixcol_enable, inv_mode, olddata,
    output newdata, mixcol_finished, busy
  );
endinterface

// File: rtl/mixcol_seq_column.sv
// Combinational (Inv)MixColumns of one 32-bit column; row 0 in the top byte.
// The inverse path exists only when MIXCOL_INV_EN is defined.
module mixcol_column
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  input  logic     inv_i,
  output aes_col_t col_o
);

  // Circulant matrix multiply with first row {k0 k1 k2 k3}.
  function automatic aes_col_t mix(input aes_col_t c, input logic [7:0] k0,
                                   input logic [7:0] k1, input logic [7:0] k2,
                                   input logic [7:0] k3);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, k0) ^ gf_mul(a1, k1) ^ gf_mul(a2, k2) ^ gf_mul(a3, k3),
            gf_mul(a0, k3) ^ gf_mul(a1, k0) ^ gf_mul(a2, k1) ^ gf_mul(a3, k2),
            gf_mul(a0, k2) ^ gf_mul(a1, k3) ^ gf_mul(a2, k0) ^ gf_mul(a3, k1),
            gf_mul(a0, k1) ^ gf_mul(a1, k2) ^ gf_mul(a2, k3) ^ gf_mul(a3, k0)};
  endfunction

  aes_col_t fwd_col;
  assign fwd_col = mix(col_i, 8'h02, 8'h03, 8'h01, 8'h01);

`ifdef MIXCOL_INV_EN
  aes_col_t inv_col;
  assign inv_col = mix(col_i, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  assign col_o   = inv_i ? inv_col : fwd_col;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign col_o      = fwd_col;
`endif

endmodule

// File: rtl/mixcol_seq.sv
// Sequential MixColumns engine transforming COLS_PER_CYCLE columns per clock in place.
// Define MIXCOL_INV_EN to build the InvMixColumns datapath selected by inv_mode.
module mixcol_seq
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  mixcol_seq_if.slave   bus
);

  localparam int unsigned NUM_PASSES = AES_NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0]  LAST_CNT   = 2'((NUM_PASSES - 1) * COLS_PER_CYCLE);
  localparam logic [1:0]  CNT_STEP   = 2'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Element 0 is the most significant word, i.e. column 0.
  typedef logic [0:AES_NUM_COLS-1][AES_COL_W-1:0] work_t;

  mixcol_state_t state_q, state_d;
  logic [1:0]    col_cnt_q, col_cnt_d;
  work_t         work_q, work_d;
  logic          inv_q, inv_d;
  logic          finished_q, finished_d;
  logic          busy_q, busy_d;

  aes_col_t      col_in  [COLS_PER_CYCLE];
  aes_col_t      col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_in[g] = work_q[col_cnt_q + 2'(g)];
    mixcol_column u_col (
      .col_i (col_in[g]),
      .inv_i (inv_q),
      .col_o (col_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mixcol_enable) begin
          state_d   = CALC;
          col_cnt_d = 2'd0;
          work_d    = bus.olddata;
`ifdef MIXCOL_INV_EN
          inv_d     = bus.inv_mode;
`else
          inv_d     = 1'b0;
`endif
        end
      end
      CALC: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          work_d[col_cnt_q + 2'(i)] = col_out[i];
        end
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered status derived from the upcoming state keeps outputs flop-driven.
    finished_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_cnt_q  <= 2'd0;
      work_q     <= '0;
      inv_q      <= 1'b0;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      work_q     <= work_d;
      inv_q      <= inv_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
    end
  end

`ifndef MIXCOL_INV_EN
  logic unused_inv_mode;
  assign unused_inv_mode = bus.inv_mode;
`endif

  assign bus.newdata         = work_q;
  assign bus.mixcol_finished = finished_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed bench for mixcol_seq with three instances (1, 2 and 4 columns per cycle).
module tb_mixcol_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  mixcol_seq_if if1 ();
  mixcol_seq_if if2 ();
  mixcol_seq_if if4 ();

  mixcol_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mixcol_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mixcol_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  localparam logic [127:0] FIPS_IN   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] KC_IN     = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] KC_OUT    = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] KC_OUT_FW = 128'hcd5045069f494f1f01010101c6c6c6c6;
  localparam logic [127:0] RS_IN     = 128'hd4d4d4d5d4d4d4d5d4d4d4d5d4d4d4d5;
  localparam logic [127:0] RS_OUT    = 128'hd5d5d7d6d5d5d7d6d5d5d7d6d5d5d7d6;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic en, input logic [127:0] data, input logic inv);
    case (d)
      1: begin if1.mixcol_enable = en; if1.olddata = data; if1.inv_mode = inv; end
      2: begin if2.mixcol_enable = en; if2.olddata = data; if2.inv_mode = inv; end
      default: begin if4.mixcol_enable = en; if4.olddata = data; if4.inv_mode = inv; end
    endcase
  endtask

  task automatic sample(input int d, output logic [127:0] nd, output logic f, output logic b);
    case (d)
      1: begin nd = if1.newdata; f = if1.mixcol_finished; b = if1.busy; end
      2: begin nd = if2.newdata; f = if2.mixcol_finished; b = if2.busy; end
      default: begin nd = if4.newdata; f = if4.mixcol_finished; b = if4.busy; end
    endcase
  endtask

  // One start pulse; inputs are scrambled right after the start edge.
  task automatic run_op(input int d, input logic [127:0] data, input logic inv,
                        input logic [127:0] exp, input int npass, input string tag);
    logic [127:0] nd;
    logic f, b;
    int n, bn;
    @(negedge clk);
    drive(d, 1'b1, data, inv);
    @(posedge clk);
    #1 drive(d, 1'b0, ~data, ~inv);
    n = 0; bn = 0; f = 1'b0;
    while (n < 20 && !f) begin
      @(negedge clk);
      n++;
      sample(d, nd, f, b);
      if (b) bn++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(npass + 1));
    chk({tag, "_busy_cycles"}, 128'(bn), 128'(npass + 1));
    chk({tag, "_data"}, nd, exp);
    @(negedge clk);
    sample(d, nd, f, b);
    chk({tag, "_fin_drop"}, 128'(f), 128'(0));
    chk({tag, "_busy_drop"}, 128'(b), 128'(0));
  endtask

  initial begin
    logic [127:0] nd;
    logic f, b;
    int pulses, last_t, bad_gap;

    drive(1, 1'b0, '0, 1'b0);
    drive(2, 1'b0, '0, 1'b0);
    drive(4, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    for (int d = 1; d <= 4; d = d * 2) begin
      sample(d, nd, f, b);
      chk($sformatf("reset_newdata_%0d", d), nd, '0);
      chk($sformatf("reset_fin_%0d", d), 128'(f), 128'(0));
      chk($sformatf("reset_busy_%0d", d), 128'(b), 128'(0));
    end
    rst = 1'b0;

    run_op(1, FIPS_IN, 1'b0, FIPS_OUT, 4, "fwd_c1");
    run_op(4, KC_IN, 1'b0, KC_OUT, 1, "kc_c4");
    run_op(2, KC_IN, 1'b0, KC_OUT, 2, "kc_c2");
`ifdef MIXCOL_INV_EN
    run_op(2, KC_OUT, 1'b1, KC_IN, 2, "inv_c2");
    run_op(4, KC_OUT, 1'b1, KC_IN, 1, "inv_c4");
`else
    run_op(2, KC_OUT, 1'b1, KC_OUT_FW, 2, "inv_off_c2");
`endif

    // Second start during CALC must be ignored.
    @(negedge clk);
    drive(1, 1'b1, FIPS_IN, 1'b0);
    @(posedge clk);
    #1 drive(1, 1'b0, FIPS_IN, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, KC_IN, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, KC_IN, 1'b0);
    pulses = 0;
    nd = '0;
    for (int i = 0; i < 10; i++) begin
      logic [127:0] t_nd;
      @(negedge clk);
      sample(1, t_nd, f, b);
      if (f) begin pulses++; nd = t_nd; end
    end
    chk("busy_start_pulses", 128'(pulses), 128'(1));
    chk("busy_start_data", nd, FIPS_OUT);

    // Reset during the second compute cycle.
    @(negedge clk);
    drive(1, 1'b1, FIPS_IN, 1'b0);
    @(posedge clk);
    #1 drive(1, 1'b0, FIPS_IN, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 sample(1, nd, f, b);
    chk("rst_mid_newdata", nd, '0);
    chk("rst_mid_busy", 128'(b), 128'(0));
    chk("rst_mid_fin", 128'(f), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample(1, nd, f, b);
      if (f || b) pulses++;
    end
    chk("rst_no_stale", 128'(pulses), 128'(0));
    run_op(1, RS_IN, 1'b0, RS_OUT, 4, "post_rst");

    // Continuous enable on the 2-column instance: period NUM_PASSES+2 = 4.
    @(negedge clk);
    drive(2, 1'b1, KC_IN, 1'b0);
    pulses = 0; last_t = -1; bad_gap = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      sample(2, nd, f, b);
      if (f) begin
        pulses++;
        chk($sformatf("cont_data_%0d", pulses), nd, KC_OUT);
        if (last_t >= 0 && (i - last_t) != 4) bad_gap++;
        if (last_t < 0 && i != 3) bad_gap++;
        last_t = i;
      end
    end
    drive(2, 1'b0, KC_IN, 1'b0);
    chk("cont_pulses", 128'(pulses), 128'(5));
    chk("cont_spacing", 128'(bad_gap), 128'(0));
    repeat (6) @(negedge clk);
    sample(2, nd, f, b);
    chk("cont_idle_busy", 128'(b), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
